psm_rdpack: RTL and testbench

Partial-sum read packer. Sits directly downstream of the partial-sum manager index counter. It takes masked SRAM read words (SRAMC_N elements per word plus a per-element active mask) and packs the active elements, in order, into dense Y-element vectors for preloading the systolic array. A valid/ready output handshake is used, with stall back-pressure toward the counter/SRAM pipeline.

---
 rtl/psm_rdpack_if.sv | 43 ++++
 rtl/psm_rdpack.sv | 176 +++++++++++++++++
 tb/tb_psm_rdpack.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/psm_rdpack_if.sv
// psm_rdpack_if
// Bundles the read-word input side and the packed-vector output side of the
// partial-sum read packer.
//   slave  : the packer (consumes words, produces vectors)
//   master : the surrounding logic / bench (produces words, consumes vectors)
// Signals:
//   i_en, i_mask, i_data, i_done, i_til_done : masked SRAM word + context tags
//   i_vec_ready                              : consumer accepts o_vec
//   o_vec, o_vec_valid, o_vec_last           : packed output vector
//   o_stall                                  : back-pressure toward the SRAM pipe
//   o_ctx_done, o_til_done                   : completion pulses
//   o_ovf_err                                : sticky "word offered while stalled"
interface psm_rdpack_if #(
    parameter int SRAMC_N = 2,
    parameter int OC_W    = 16,
    parameter int Y       = 8
);
    logic                    i_en;
    logic [0:SRAMC_N-1]      i_mask;
    logic [SRAMC_N*OC_W-1:0] i_data;
    logic                    i_done;
    logic                    i_til_done;
    logic                    i_vec_ready;
    logic [Y*OC_W-1:0]       o_vec;
    logic                    o_vec_valid;
    logic                    o_vec_last;
    logic                    o_stall;
    logic                    o_ctx_done;
    logic                    o_til_done;
    logic                    o_ovf_err;

    modport slave (
        input  i_en, i_mask, i_data, i_done, i_til_done, i_vec_ready,
        output o_vec, o_vec_valid, o_vec_last, o_stall,
               o_ctx_done, o_til_done, o_ovf_err
    );

    modport master (
        output i_en, i_mask, i_data, i_done, i_til_done, i_vec_ready,
        input  o_vec, o_vec_valid, o_vec_last, o_stall,
               o_ctx_done, o_til_done, o_ovf_err
    );
endinterface

// File: rtl/psm_rdpack.sv
// psm_rdpack
// Partial-sum read packer. Takes masked SRAM read words (SRAMC_N elements plus
// a per-element active mask), appends the active elements in order into an
// accumulation buffer and emits dense Y-element vectors over a valid/ready
// handshake. The last word of a context forces out a zero-padded final vector;
// if that word overflows past Y, the spill is emitted from a FLUSH state.
// Requires SRAMC_N <= Y.
// Ports:
//   i_clk   : clock
//   i_rstn  : asynchronous active-low reset
//   i_clear : synchronous clear of all state, including the error flag
//   bus     : psm_rdpack_if.slave (input word side and output vector side)
module psm_rdpack #(
    parameter int SRAMC_N = 2,
    parameter int OC_W    = 16,
    parameter int Y       = 8,
    parameter int FILL_W  = $clog2(Y + SRAMC_N)
) (
    input  logic         i_clk,
    input  logic         i_rstn,
    input  logic         i_clear,
    psm_rdpack_if.slave  bus
);
    // Worst case held elements: Y-1 left over plus a full word.
    localparam int                CAT_N = Y + SRAMC_N - 1;
    localparam logic [FILL_W-1:0] Y_F   = FILL_W'(Y);

    typedef enum logic {S_FILL, S_FLUSH} state_t;

    state_t            r_state;
    logic [OC_W-1:0]   r_buf [CAT_N];
    logic [FILL_W-1:0] r_fill;
    logic [OC_W-1:0]   r_vec [Y];
    logic              r_vld;
    logic              r_last;
    logic              r_vec_til;   // til flag riding with the vector in r_vec
    logic              r_til;       // til flag held across FLUSH
    logic              r_ctx_done;
    logic              r_til_done;
    logic              r_ovf;

    logic [OC_W-1:0]   w_base  [CAT_N];  // buffer with stale slots forced to 0
    logic [OC_W-1:0]   w_cat   [CAT_N];  // buffer plus appended active elements
    logic [OC_W-1:0]   w_shift [CAT_N];  // w_cat after removing an emitted vector
    logic [FILL_W-1:0] w_cnt;
    logic [FILL_W-1:0] w_fill_new;
    logic              w_stall;
    logic              w_free;
    logic              w_xfer;
    logic              w_acc;

    assign w_xfer  = r_vld & bus.i_vec_ready;
    assign w_free  = ~r_vld | bus.i_vec_ready;
    // Depends only on registered state and i_vec_ready, never on the word.
    assign w_stall = (r_vld & ~bus.i_vec_ready) | (r_state == S_FLUSH);
    assign w_acc   = bus.i_en & ~w_stall;

    // Compaction: each active element lands at fill + (active elements before it).
    always_comb begin
        w_cnt = '0;
        for (int k = 0; k < CAT_N; k++) begin
            w_base[k] = (FILL_W'(k) < r_fill) ? r_buf[k] : '0;
            w_cat[k]  = w_base[k];
        end
        for (int i = 0; i < SRAMC_N; i++) begin
            if (bus.i_mask[i]) begin
                if (int'(r_fill) + int'(w_cnt) < CAT_N)
                    w_cat[int'(r_fill) + int'(w_cnt)] = bus.i_data[i*OC_W +: OC_W];
                w_cnt = w_cnt + 1'b1;
            end
        end
        w_fill_new = r_fill + w_cnt;
        for (int k = 0; k < CAT_N; k++)
            w_shift[k] = '0;
        for (int k = 0; k < CAT_N - Y; k++)
            w_shift[k] = w_cat[k + Y];
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state    <= S_FILL;
            r_fill     <= '0;
            r_vld      <= 1'b0;
            r_last     <= 1'b0;
            r_vec_til  <= 1'b0;
            r_til      <= 1'b0;
            r_ctx_done <= 1'b0;
            r_til_done <= 1'b0;
            r_ovf      <= 1'b0;
            for (int k = 0; k < CAT_N; k++) r_buf[k] <= '0;
            for (int j = 0; j < Y; j++)     r_vec[j] <= '0;
        end else if (i_clear) begin
            r_state    <= S_FILL;
            r_fill     <= '0;
            r_vld      <= 1'b0;
            r_last     <= 1'b0;
            r_vec_til  <= 1'b0;
            r_til      <= 1'b0;
            r_ctx_done <= 1'b0;
            r_til_done <= 1'b0;
            r_ovf      <= 1'b0;
            for (int k = 0; k < CAT_N; k++) r_buf[k] <= '0;
            for (int j = 0; j < Y; j++)     r_vec[j] <= '0;
        end else begin
            // Completion pulses follow the transfer of a last vector by one cycle.
            r_ctx_done <= w_xfer & r_last;
            r_til_done <= w_xfer & r_last & r_vec_til;
            if (bus.i_en && w_stall && (|bus.i_mask))
                r_ovf <= 1'b1;
            if (w_xfer)
                r_vld <= 1'b0;

            case (r_state)
                S_FILL: begin
                    if (w_acc) begin
                        if (w_fill_new >= Y_F) begin
                            for (int j = 0; j < Y; j++)     r_vec[j] <= w_cat[j];
                            for (int k = 0; k < CAT_N; k++) r_buf[k] <= w_shift[k];
                            r_vld     <= 1'b1;
                            r_fill    <= w_fill_new - Y_F;
                            // Exactly Y elements on a done word: this is already the last vector.
                            r_last    <= bus.i_done && (w_fill_new == Y_F);
                            r_vec_til <= bus.i_done && bus.i_til_done && (w_fill_new == Y_F);
                            if (bus.i_done && (w_fill_new > Y_F)) begin
                                r_til   <= bus.i_til_done;
                                r_state <= S_FLUSH;
                            end
                        end else if (bus.i_done) begin
                            r_fill <= '0;
                            for (int k = 0; k < CAT_N; k++) r_buf[k] <= '0;
                            if (w_fill_new != '0) begin
                                // Slots at and above fill_new are already zero in w_cat.
                                for (int j = 0; j < Y; j++) r_vec[j] <= w_cat[j];
                                r_vld     <= 1'b1;
                                r_last    <= 1'b1;
                                r_vec_til <= bus.i_til_done;
                            end else begin
                                // Empty context: nothing to emit, report completion directly.
                                r_ctx_done <= 1'b1;
                                r_til_done <= (w_xfer & r_last & r_vec_til) | bus.i_til_done;
                            end
                        end else begin
                            for (int k = 0; k < CAT_N; k++) r_buf[k] <= w_cat[k];
                            r_fill <= w_fill_new;
                        end
                    end
                end
                S_FLUSH: begin
                    if (w_free) begin
                        for (int j = 0; j < Y; j++)     r_vec[j] <= w_base[j];
                        for (int k = 0; k < CAT_N; k++) r_buf[k] <= '0;
                        r_vld     <= 1'b1;
                        r_last    <= 1'b1;
                        r_vec_til <= r_til;
                        r_til     <= 1'b0;
                        r_fill    <= '0;
                        r_state   <= S_FILL;
                    end
                end
                default: r_state <= S_FILL;
            endcase
        end
    end

    for (genvar j = 0; j < Y; j++) begin : g_vec
        assign bus.o_vec[j*OC_W +: OC_W] = r_vec[j];
    end

    assign bus.o_vec_valid = r_vld;
    assign bus.o_vec_last  = r_last;
    assign bus.o_stall     = w_stall;
    assign bus.o_ctx_done  = r_ctx_done;
    assign bus.o_til_done  = r_til_done;
    assign bus.o_ovf_err   = r_ovf;

endmodule

// File: tb/tb_psm_rdpack.sv
// tb_psm_rdpack
// Directed bench for psm_rdpack with Y=4, SRAMC_N=2, OC_W=16.
module tb_psm_rdpack;
    localparam int SN = 2;
    localparam int OW = 16;
    localparam int YY = 4;

    logic clk;
    logic rstn;
    logic clr;
    int   n_chk;
    int   n_bad;

    psm_rdpack_if #(.SRAMC_N(SN), .OC_W(OW), .Y(YY)) bus ();

    psm_rdpack #(.SRAMC_N(SN), .OC_W(OW), .Y(YY)) dut (
        .i_clk  (clk),
        .i_rstn (rstn),
        .i_clear(clr),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] v4(input logic [15:0] a, b, c, d);
        return {d, c, b, a};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [0:1] m, input logic [15:0] e0, e1,
                         input logic d, t);
        bus.i_en       = 1'b1;
        bus.i_mask     = m;
        bus.i_data     = {e1, e0};
        bus.i_done     = d;
        bus.i_til_done = t;
    endtask

    task automatic idle();
        bus.i_en       = 1'b0;
        bus.i_mask     = 2'b00;
        bus.i_data     = '0;
        bus.i_done     = 1'b0;
        bus.i_til_done = 1'b0;
    endtask

    initial begin
        n_chk = 0;
        n_bad = 0;
        rstn  = 1'b0;
        clr   = 1'b0;
        bus.i_vec_ready = 1'b1;
        idle();
        tick();
        tick();

        // reset state
        chk("rst_valid", bus.o_vec_valid, 1'b0);
        chk("rst_vec",   bus.o_vec, 64'h0);
        chk("rst_last",  bus.o_vec_last, 1'b0);
        chk("rst_stall", bus.o_stall, 1'b0);
        chk("rst_ctx",   bus.o_ctx_done, 1'b0);
        chk("rst_til",   bus.o_til_done, 1'b0);
        chk("rst_ovf",   bus.o_ovf_err, 1'b0);
        rstn = 1'b1;
        tick();

        // dense stream
        drive(2'b11, 16'h000A, 16'h000B, 1'b0, 1'b0);
        tick();
        chk("dense_nov", bus.o_vec_valid, 1'b0);
        drive(2'b11, 16'h000C, 16'h000D, 1'b0, 1'b0);
        tick();
        idle();
        chk("dense_valid", bus.o_vec_valid, 1'b1);
        chk("dense_vec",   bus.o_vec, v4(16'h000A, 16'h000B, 16'h000C, 16'h000D));
        chk("dense_last",  bus.o_vec_last, 1'b0);
        tick();
        chk("dense_gone",  bus.o_vec_valid, 1'b0);
        chk("dense_noctx", bus.o_ctx_done, 1'b0);

        // sparse masks
        drive(2'b01, 16'hDEAD, 16'h1001, 1'b0, 1'b0);
        tick();
        drive(2'b11, 16'h1002, 16'h1003, 1'b0, 1'b0);
        tick();
        chk("sparse_nov", bus.o_vec_valid, 1'b0);
        drive(2'b10, 16'h1004, 16'hBEEF, 1'b0, 1'b0);
        tick();
        idle();
        chk("sparse_valid", bus.o_vec_valid, 1'b1);
        chk("sparse_vec",   bus.o_vec, v4(16'h1001, 16'h1002, 16'h1003, 16'h1004));
        tick();

        // done overflow: fill=3 then a done word of two elements
        drive(2'b11, 16'h2001, 16'h2002, 1'b0, 1'b0);
        tick();
        drive(2'b01, 16'hDEAD, 16'h2003, 1'b0, 1'b0);
        tick();
        chk("ovfl_nov", bus.o_vec_valid, 1'b0);
        drive(2'b11, 16'h2004, 16'h2005, 1'b1, 1'b0);
        tick();
        idle();
        chk("ovfl_vec1",  bus.o_vec, v4(16'h2001, 16'h2002, 16'h2003, 16'h2004));
        chk("ovfl_last1", bus.o_vec_last, 1'b0);
        chk("ovfl_stall", bus.o_stall, 1'b1);
        tick();
        chk("ovfl_valid2", bus.o_vec_valid, 1'b1);
        chk("ovfl_vec2",   bus.o_vec, v4(16'h2005, 16'h0, 16'h0, 16'h0));
        chk("ovfl_last2",  bus.o_vec_last, 1'b1);
        chk("ovfl_ctx0",   bus.o_ctx_done, 1'b0);
        chk("ovfl_stall2", bus.o_stall, 1'b0);
        tick();
        chk("ovfl_ctx1",  bus.o_ctx_done, 1'b1);
        chk("ovfl_notil", bus.o_til_done, 1'b0);
        chk("ovfl_gone",  bus.o_vec_valid, 1'b0);
        tick();
        chk("ovfl_ctx2", bus.o_ctx_done, 1'b0);

        // back-pressure
        bus.i_vec_ready = 1'b0;
        drive(2'b11, 16'h3001, 16'h3002, 1'b0, 1'b0);
        tick();
        drive(2'b11, 16'h3003, 16'h3004, 1'b0, 1'b0);
        tick();
        idle();
        chk("bp_stall", bus.o_stall, 1'b1);
        tick();
        chk("bp_hold_vld", bus.o_vec_valid, 1'b1);
        chk("bp_hold_vec", bus.o_vec, v4(16'h3001, 16'h3002, 16'h3003, 16'h3004));
        chk("bp_noerr",    bus.o_ovf_err, 1'b0);
        drive(2'b11, 16'h3005, 16'h3006, 1'b0, 1'b0);
        #1;
        chk("bp_stall_en", bus.o_stall, 1'b1);
        tick();
        idle();
        chk("bp_err",      bus.o_ovf_err, 1'b1);
        chk("bp_hold_vec2", bus.o_vec, v4(16'h3001, 16'h3002, 16'h3003, 16'h3004));
        bus.i_vec_ready = 1'b1;
        #1;
        chk("bp_release", bus.o_stall, 1'b0);
        tick();
        chk("bp_gone",   bus.o_vec_valid, 1'b0);
        chk("bp_sticky", bus.o_ovf_err, 1'b1);

        // tiling done
        drive(2'b11, 16'h4001, 16'h4002, 1'b1, 1'b1);
        tick();
        idle();
        chk("til_vec",  bus.o_vec, v4(16'h4001, 16'h4002, 16'h0, 16'h0));
        chk("til_last", bus.o_vec_last, 1'b1);
        tick();
        chk("til_ctx", bus.o_ctx_done, 1'b1);
        chk("til_til", bus.o_til_done, 1'b1);
        tick();
        chk("til_ctx_off", bus.o_ctx_done, 1'b0);
        chk("til_til_off", bus.o_til_done, 1'b0);

        // empty done word
        drive(2'b00, 16'h0, 16'h0, 1'b1, 1'b0);
        tick();
        idle();
        chk("empty_nov", bus.o_vec_valid, 1'b0);
        chk("empty_ctx", bus.o_ctx_done, 1'b1);
        tick();
        chk("empty_ctx_off", bus.o_ctx_done, 1'b0);

        // clear mid-vector
        drive(2'b11, 16'h5001, 16'h5002, 1'b0, 1'b0);
        tick();
        idle();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_err", bus.o_ovf_err, 1'b0);
        chk("clr_nov", bus.o_vec_valid, 1'b0);
        drive(2'b11, 16'h5003, 16'h5004, 1'b0, 1'b0);
        tick();
        chk("clr_nov2", bus.o_vec_valid, 1'b0);
        drive(2'b11, 16'h5005, 16'h5006, 1'b0, 1'b0);
        tick();
        idle();
        chk("clr_vec", bus.o_vec, v4(16'h5003, 16'h5004, 16'h5005, 16'h5006));
        tick();

        // reset mid-vector
        drive(2'b11, 16'h6001, 16'h6002, 1'b1, 1'b0);
        #2;
        idle();
        rstn = 1'b0;
        #2;
        rstn = 1'b1;
        tick();
        chk("arst_nov", bus.o_vec_valid, 1'b0);
        chk("arst_ctx", bus.o_ctx_done, 1'b0);
        drive(2'b11, 16'h6003, 16'h6004, 1'b0, 1'b0);
        tick();
        idle();
        chk("arst_nov2", bus.o_vec_valid, 1'b0);
        tick();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
